// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor status framer: ASCII frame
// characters and the frame FSM state encoding.
package sensor_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        TERM = 2'd3
    } frame_state_e;

    function automatic logic [7:0] flag_char(input logic active);
        return active ? ASCII_ONE : ASCII_ZERO;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, stability counter and accepted
// level. Exposes the next accepted level so the owner can register in step.
module sensor_debounce #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter logic        INACTIVE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_raw,
    output logic level_next,
    output logic accept
);

    localparam int unsigned      CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // The counter never stores DEB_CYCLES itself: the cycle it would reach it
    // is the cycle the new level is taken and the count restarts.
    always_comb begin
        accept     = (sync_q2 != level) && (cnt == CNT_LAST);
        level_next = accept ? sync_q2 : level;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (sync_q2 sees old sync_q1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= INACTIVE;
            sync_q2 <= INACTIVE;
            level   <= INACTIVE;
            cnt     <= '0;
        end else begin
            sync_q1 <= sensor_raw;
            sync_q2 <= sync_q1;
            level   <= level_next;
            if ((sync_q2 == level) || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_status_framer.sv
// Debounces N_CH binary sensors into ASCII '0'/'1' flags and streams a
// status frame "S<flags MSB..LSB>\n" over a valid/ready byte interface.
module sensor_status_framer
    import sensor_pkg::*;
#(
    parameter int unsigned     N_CH       = 3,
    parameter int unsigned     DEB_CYCLES = 16,
    parameter logic [N_CH-1:0] ACT_POL    = {N_CH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   sensor_in,
    input  logic              send_req,
    output logic [8*N_CH-1:0] ascii_out,
    output logic              change_pulse,
    output logic              frame_valid,
    output logic [7:0]        frame_byte,
    input  logic              frame_ready
);

    localparam logic [3:0] IDX_LAST = 4'(N_CH - 1);

    logic [N_CH-1:0]   level_next;
    logic [N_CH-1:0]   accept;
    logic [8*N_CH-1:0] ascii_next;
    logic [8*N_CH-1:0] ascii_q;
    logic [8*N_CH-1:0] snap_q;
    logic              change_q;
    logic              pending;
    logic              frame_start;
    logic [3:0]        data_idx;
    logic [7:0]        data_byte;
    frame_state_e      state;
    frame_state_e      state_next;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sensor_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .INACTIVE   (~ACT_POL[c])
        ) u_debounce (
            .clk        (clk),
            .rst_n      (rst_n),
            .sensor_raw (sensor_in[c]),
            .level_next (level_next[c]),
            .accept     (accept[c])
        );
    end

    // Flags are derived from the next accepted level so ascii_out moves on
    // the same edge as the debouncer's accepted level.
    always_comb begin
        ascii_next = '0;
        for (int c = 0; c < N_CH; c++) begin
            ascii_next[8*c +: 8] = flag_char(level_next[c] ~^ ACT_POL[c]);
        end
    end

    assign frame_start = (state == IDLE) && pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ascii_q  <= {N_CH{ASCII_ZERO}};
            change_q <= 1'b0;
            pending  <= 1'b0;
        end else begin
            ascii_q  <= ascii_next;
            change_q <= |accept;
            if (frame_start) begin
                pending <= 1'b0;
            end else if (change_q || send_req) begin
                pending <= 1'b1;
            end
        end
    end

    assign ascii_out    = ascii_q;
    assign change_pulse = change_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        frame_valid = 1'b0;
        frame_byte  = 8'h00;
        data_byte   = ASCII_ZERO;
        for (int c = 0; c < N_CH; c++) begin
            if (data_idx == 4'(N_CH - 1 - c)) begin
                data_byte = snap_q[8*c +: 8];
            end
        end
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                frame_valid = 1'b1;
                frame_byte  = ASCII_S;
                if (frame_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                frame_valid = 1'b1;
                frame_byte  = data_byte;
                if (frame_ready && (data_idx == IDX_LAST)) begin
                    state_next = TERM;
                end
            end
            TERM: begin
                frame_valid = 1'b1;
                frame_byte  = ASCII_LF;
                if (frame_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The snapshot freezes the flags for the whole frame; later changes
    // only raise pending and go out in the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q   <= {N_CH{ASCII_ZERO}};
            data_idx <= '0;
        end else begin
            if (frame_start) begin
                snap_q   <= ascii_q;
                data_idx <= '0;
            end else if ((state == DATA) && frame_ready) begin
                data_idx <= data_idx + 1'b1;
            end
        end
    end

endmodule
